// File: rtl/board_engine.sv
// board_engine: N x N Othello board store with a one-cell-per-cycle move engine
// (DETECT / PLACE with flipping), disk counters and a registered plot read port.
// Define BOARD_DIAG_EN to scan and flip the four diagonal directions as well.
module board_engine #(
  parameter int N = 8,
  localparam int CW = $clog2(N),
  localparam int CNTW = 2 * CW + 1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic            side,
  input  logic [CW-1:0]   x,
  input  logic [CW-1:0]   y,
  output logic            done,
  output logic            legal,
  output logic [7:0]      dir,
  input  logic [CW-1:0]   rd_x,
  input  logic [CW-1:0]   rd_y,
  output logic [1:0]      rd_data,
  output logic [CNTW-1:0] white_cnt,
  output logic [CNTW-1:0] black_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ORIGIN, S_SCAN, S_FLIP, S_DONE} state_t;

  localparam logic [1:0]      CELL_EMPTY = 2'b00;
  localparam logic [1:0]      CELL_WHITE = 2'b10;
  localparam logic [1:0]      CELL_BLACK = 2'b11;
  localparam logic [CW:0]     K_ZERO     = '0;
  localparam logic [CW:0]     K_ONE      = (CW + 1)'(1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_INIT   = CNTW'(2);
  localparam int              C_LO       = N / 2 - 1;
  localparam int              C_HI       = N / 2;

`ifdef BOARD_DIAG_EN
  localparam logic [2:0] DIR_STEP = 3'd1;
  localparam logic [2:0] DIR_LAST = 3'd7;
  localparam logic [7:0] DIR_MASK = 8'hFF;
`else
  localparam logic [2:0] DIR_STEP = 3'd2;
  localparam logic [2:0] DIR_LAST = 3'd6;
  localparam logic [7:0] DIR_MASK = 8'h55;
`endif

  state_t            state_q, state_d;
  logic              op_q, side_q;
  logic [CW-1:0]     x_q, y_q;
  logic [2:0]        d_q, d_d;
  logic [CW:0]       k_q, k_d;
  logic [7:0]        dir_q, dir_d;
  logic [CNTW-1:0]   white_q, black_q;
  logic [1:0]        rd_data_q;
  logic [1:0]        cells [N*N];

  logic [CW:0]       px, py;
  logic              off_board;
  logic [2*CW-1:0]   probe_idx;
  logic [1:0]        probe_cell, mover, opp;
  logic              accept, wr_en, flip;
  logic [3:0]        nxt;

  function automatic logic [1:0] init_cell(input int idx);
    if (idx == C_LO * N + C_LO || idx == C_HI * N + C_HI) return CELL_WHITE;
    if (idx == C_LO * N + C_HI || idx == C_HI * N + C_LO) return CELL_BLACK;
    return CELL_EMPTY;
  endfunction

  // Lowest set bit of mask at index >= from; result is {found, index}.
  function automatic logic [3:0] first_set(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (mask[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    return r;
  endfunction

  assign mover = {1'b1, side_q};
  assign opp   = {1'b1, ~side_q};

  // Probe address = target + k * step(d). With k = 0 it is the target itself,
  // so the origin read and origin write share the single cell access path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    px = {1'b0, x_q};
    py = {1'b0, y_q};
    case (d_q)
      3'd0: py = {1'b0, y_q} - k_q;
      3'd1: begin px = {1'b0, x_q} + k_q; py = {1'b0, y_q} - k_q; end
      3'd2: px = {1'b0, x_q} + k_q;
      3'd3: begin px = {1'b0, x_q} + k_q; py = {1'b0, y_q} + k_q; end
      3'd4: py = {1'b0, y_q} + k_q;
      3'd5: begin px = {1'b0, x_q} - k_q; py = {1'b0, y_q} + k_q; end
      3'd6: px = {1'b0, x_q} - k_q;
      default: begin px = {1'b0, x_q} - k_q; py = {1'b0, y_q} - k_q; end
    endcase
  end

  // A walk stops at its first off-board probe, so coordinates only reach -1 or N;
  // both set the extra MSB.
  assign off_board  = px[CW] | py[CW];
  assign probe_idx  = {py[CW-1:0], px[CW-1:0]};
  assign probe_cell = cells[probe_idx];

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    k_d     = k_q;
    dir_d   = dir_q;
    accept  = 1'b0;
    wr_en   = 1'b0;
    flip    = 1'b0;
    nxt     = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          dir_d   = '0;
          d_d     = 3'd0;
          k_d     = K_ZERO;
          state_d = S_ORIGIN;
        end
      end
      S_ORIGIN: begin
        if (probe_cell != CELL_EMPTY) begin
          state_d = S_DONE;
        end else begin
          d_d     = 3'd0;
          k_d     = K_ONE;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!off_board && probe_cell == opp) begin
          k_d = k_q + K_ONE;
        end else begin
          dir_d[d_q] = !off_board && (probe_cell == mover) && (k_q != K_ONE);
          if (d_q == DIR_LAST) begin
            k_d     = K_ZERO;
            state_d = (op_q && dir_d != 8'h00) ? S_FLIP : S_DONE;
          end else begin
            d_d = d_q + DIR_STEP;
            k_d = K_ONE;
          end
        end
      end
      S_FLIP: begin
        if (k_q == K_ZERO) begin
          wr_en = 1'b1;
          nxt   = first_set(dir_q, 4'd0);
          d_d   = nxt[2:0];
          k_d   = K_ONE;
        end else if (probe_cell == mover) begin
          nxt = first_set(dir_q, {1'b0, d_q} + 4'd1);
          if (nxt[3]) begin
            d_d = nxt[2:0];
            k_d = K_ONE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          wr_en = 1'b1;
          flip  = 1'b1;
          k_d   = k_q + K_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      side_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      d_q       <= 3'd0;
      k_q       <= K_ZERO;
      dir_q     <= '0;
      white_q   <= CNT_INIT;
      black_q   <= CNT_INIT;
      rd_data_q <= CELL_EMPTY;
      // NOTE: the board is a flop array, not a RAM macro, because reset must
      // restore the opening position in a single edge.
      for (int i = 0; i < N * N; i++) cells[i] <= init_cell(i);
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      k_q       <= k_d;
      dir_q     <= dir_d;
      rd_data_q <= cells[{rd_y, rd_x}];
      if (accept) begin
        op_q   <= cmd_op;
        side_q <= side;
        x_q    <= x;
        y_q    <= y;
      end
      if (wr_en) begin
        cells[probe_idx] <= mover;
        if (side_q) begin
          black_q <= black_q + CNT_ONE;
          if (flip) white_q <= white_q - CNT_ONE;
        end else begin
          white_q <= white_q + CNT_ONE;
          if (flip) black_q <= black_q - CNT_ONE;
        end
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dir       = dir_q & DIR_MASK;
  assign legal     = |(dir_q & DIR_MASK);
  assign rd_data   = rd_data_q;
  assign white_cnt = white_q;
  assign black_cnt = black_q;

endmodule

// File: tb/tb_board_engine.sv
// Directed self-checking bench for board_engine (N = 8); expected directions and
// latencies are hand-derived and adapt to BOARD_DIAG_EN.
module tb_board_engine;
  localparam int N    = 8;
  localparam int CW   = 3;
  localparam int CNTW = 7;

`ifdef BOARD_DIAG_EN
  localparam int         P_23    = 9;
  localparam int         P_22    = 10;
  localparam int         P_CORN  = 8;
  localparam logic [7:0] DIR_22  = 8'h08;
`else
  localparam int         P_23    = 5;
  localparam int         P_22    = 5;
  localparam int         P_CORN  = 4;
  localparam logic [7:0] DIR_22  = 8'h00;
`endif

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_op = 1'b0;
  logic            side = 1'b0;
  logic [CW-1:0]   x = '0, y = '0, rd_x = '0, rd_y = '0;
  logic            cmd_ready, done, legal;
  logic [7:0]      dir;
  logic [1:0]      rd_data;
  logic [CNTW-1:0] white_cnt, black_cnt;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_b [N][N];  // [y][x]

  board_engine #(.N(N)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .side(side),
    .x(x), .y(y), .done(done), .legal(legal), .dir(dir),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .white_cnt(white_cnt), .black_cnt(black_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic init_expected();
    for (int yy = 0; yy < N; yy++)
      for (int xx = 0; xx < N; xx++) exp_b[yy][xx] = 2'b00;
    exp_b[3][3] = 2'b10;
    exp_b[4][4] = 2'b10;
    exp_b[3][4] = 2'b11;
    exp_b[4][3] = 2'b11;
  endtask

  task automatic check_counts(input string tag, input int w, input int b);
    check({tag, "_white"}, 32'(white_cnt), 32'(w));
    check({tag, "_black"}, 32'(black_cnt), 32'(b));
  endtask

  task automatic dump_board(input string tag);
    for (int yy = 0; yy < N; yy++)
      for (int xx = 0; xx < N; xx++) begin
        @(negedge clock);
        rd_x = CW'(xx);
        rd_y = CW'(yy);
        @(negedge clock);
        check($sformatf("%s_cell_%0d_%0d", tag, xx, yy), 32'(rd_data), 32'(exp_b[yy][xx]));
      end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_dir"},   32'(dir), 32'd0);
    check({tag, "_legal"}, 32'(legal), 32'd0);
    check({tag, "_rd"},    32'(rd_data), 32'd0);
    check_counts(tag, 2, 2);
    resetn = 1'b1;
    init_expected();
  endtask

  task automatic run_cmd(input logic op, input logic s, input int cx, input int cy,
                         input int exp_cyc, input logic [7:0] exp_dir, input string tag);
    int cyc;
    bit seen;
    @(negedge clock);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    side      = s;
    x         = CW'(cx);
    y         = CW'(cy);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 300 && !seen) begin
      @(negedge clock);
      if (cyc == 1) check({tag, "_busy"}, 32'(cmd_ready), 32'd0);
      if (done) seen = 1'b1;
      else begin
        @(posedge clock);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
    check({tag, "_legal"}, 32'(legal), 32'(exp_dir != 8'h00));
    @(negedge clock);
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;

    apply_reset("reset");
    dump_board("reset");

    run_cmd(1'b0, 1'b1, 2, 3, 2 + P_23, 8'h04, "det_b_2_3");
    check_counts("det_b_2_3", 2, 2);
    dump_board("det_b_2_3");

    run_cmd(1'b1, 1'b1, 2, 3, 2 + P_23 + 3, 8'h04, "place_b_2_3");
    exp_b[3][2] = 2'b11;
    exp_b[3][3] = 2'b11;
    check_counts("place_b_2_3", 1, 4);
    dump_board("place_b_2_3");

    run_cmd(1'b0, 1'b1, 2, 3, 2, 8'h00, "det_occupied");

    run_cmd(1'b0, 1'b0, 2, 2, 2 + P_22, DIR_22, "det_w_2_2");

    apply_reset("reset2");
    run_cmd(1'b0, 1'b1, 0, 0, 2 + P_CORN, 8'h00, "det_b_0_0");
    run_cmd(1'b0, 1'b1, 7, 7, 2 + P_CORN, 8'h00, "det_b_7_7");
    run_cmd(1'b1, 1'b1, 0, 0, 2 + P_CORN, 8'h00, "place_b_0_0");
    check_counts("place_b_0_0", 2, 2);
    dump_board("place_b_0_0");

    // Abort a PLACE after the origin write and the single flip have landed.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    side      = 1'b1;
    x         = CW'(2);
    y         = CW'(3);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    seen = 1'b0;
    repeat (P_23 + 3) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      @(posedge clock);
    end
    @(negedge clock);
    if (done) seen = 1'b1;
    check_counts("abort_midflip", 1, 4);
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    if (done) seen = 1'b1;
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_dir", 32'(dir), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check_counts("abort", 2, 2);
    init_expected();
    dump_board("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
